// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: per-channel divide counters with
// staged ratio updates, a post-reset lock gate and a boundary-aligned
// strobe selector.
module clk_enable_gen #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEF_DIV     = 2,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cfg_valid,
  input  logic [SEL_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ready,
  input  logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] ce,
  output logic              sel_ce,
  output logic [SEL_W-1:0]  sel_active,
  output logic              sel_switching,
  output logic              locked
);

  localparam int unsigned      LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_DEF   = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [SEL_W:0]    NUM_CH_W  = (SEL_W + 1)'(NUM_CH);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_OLD = 2'd1;
  localparam logic [1:0] ST_WAIT_NEW = 2'd2;

  logic [LOCK_W-1:0] lock_cnt;

  logic [DIV_W-1:0]  cnt_q  [NUM_CH];
  logic [DIV_W-1:0]  cnt_d  [NUM_CH];
  logic [DIV_W-1:0]  div_q  [NUM_CH];
  logic [DIV_W-1:0]  div_d  [NUM_CH];
  logic [DIV_W-1:0]  pdiv_q [NUM_CH];
  logic [DIV_W-1:0]  pdiv_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pend_d;
  logic [NUM_CH-1:0] ce_d;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [SEL_W-1:0]  target_q;
  logic [SEL_W-1:0]  target_d;
  logic [SEL_W-1:0]  active_d;
  logic              act_ce;
  logic              sel_ok;

  // Lock counter: locked rises on the LOCK_CYCLES-th edge after release.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (!locked) begin
      if (lock_cnt == LOCK_LAST) begin
        locked <= 1'b1;
      end else begin
        lock_cnt <= lock_cnt + LOCK_W'(1);
      end
    end
  end

  // Update acceptance: out-of-range channels are always ready (and dropped).
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (cfg_ch == SEL_W'(i)) begin
        cfg_ready = ~pend_q[i];
      end
    end
  end

  // Per-channel divide counter, staged ratio apply on period boundary, accept.
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      pdiv_d[i] = pdiv_q[i];
      pend_d[i] = pend_q[i];
      ce_d[i]   = 1'b0;
      if (locked) begin
        if (div_q[i] <= DIV_ONE) begin
          ce_d[i]  = 1'b1;
          cnt_d[i] = '0;
        end else if (cnt_q[i] == div_q[i] - DIV_ONE) begin
          ce_d[i]  = 1'b1;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_ONE;
        end
      end else begin
        cnt_d[i] = '0;
      end
      // ce_d doubles as the boundary marker (wrap edge or ratio <= 1)
      if (pend_q[i] && (!locked || ce_d[i])) begin
        div_d[i]  = pdiv_q[i];
        pend_d[i] = 1'b0;
      end
      if (cfg_valid && (cfg_ch == SEL_W'(i)) && !pend_q[i]) begin
        pend_d[i] = 1'b1;
        pdiv_d[i] = cfg_div;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DIV_DEF;
        pdiv_q[i] <= '0;
      end
      pend_q <= '0;
      ce     <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pdiv_q[i] <= pdiv_d[i];
      end
      pend_q <= pend_d;
      ce     <= ce_d;
    end
  end

  // Strobe of the channel currently driving sel_ce, and request validity.
  always_comb begin
    act_ce = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (sel_active == SEL_W'(i)) begin
        act_ce = ce[i];
      end
    end
    sel_ok = ({1'b0, sel} < NUM_CH_W);
  end

  // Selector next state: hand over only on old then new channel pulses.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    active_d = sel_active;
    case (state_q)
      ST_IDLE: begin
        if ((sel != sel_active) && sel_ok) begin
          target_d = sel;
          state_d  = ST_WAIT_OLD;
        end
      end
      ST_WAIT_OLD: begin
        if (locked && act_ce) begin
          active_d = target_q;
          state_d  = ST_WAIT_NEW;
        end
      end
      ST_WAIT_NEW: begin
        if (locked && act_ce) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Selector state and registered selector outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      sel_active    <= '0;
      sel_switching <= 1'b0;
      sel_ce        <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      sel_active    <= active_d;
      sel_switching <= (state_d != ST_IDLE);
      sel_ce        <= act_ce;
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen (NUM_CH=3, DEF_DIV=2, LOCK_CYCLES=4).
module tb_clk_enable_gen;

  logic       CLK;
  logic       RESET;
  logic       cfg_valid;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic [1:0] sel;
  logic [2:0] ce;
  logic       sel_ce;
  logic [1:0] sel_active;
  logic       sel_switching;
  logic       locked;

  int n_checks = 0;
  int n_errors = 0;

  clk_enable_gen #(
    .NUM_CH(3), .SEL_W(2), .DIV_W(8), .DEF_DIV(2), .LOCK_CYCLES(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready), .sel(sel), .ce(ce),
    .sel_ce(sel_ce), .sel_active(sel_active), .sel_switching(sel_switching),
    .locked(locked)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Cycles until the next ce pulse on channel ch (bounded).
  task automatic measure(input int ch, input int exp, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ce[ch] == 1'b0 && n < 40);
    chk(tag, 32'(n), 32'(exp));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ce"},   32'(ce), 0);
    chk({tag, "_sce"},  32'(sel_ce), 0);
    chk({tag, "_sact"}, 32'(sel_active), 0);
    chk({tag, "_sw"},   32'(sel_switching), 0);
    chk({tag, "_lock"}, 32'(locked), 0);
    chk({tag, "_rdy"},  32'(cfg_ready), 1);
  endtask

  task automatic lock_sequence(input string tag);
    repeat (3) tick();
    chk({tag, "_e3_lock"}, 32'(locked), 0);
    chk({tag, "_e3_ce"}, 32'(ce), 0);
    tick();
    chk({tag, "_e4_lock"}, 32'(locked), 1);
    chk({tag, "_e4_ce"}, 32'(ce), 0);
    tick();
    chk({tag, "_e5_ce"}, 32'(ce), 0);
    tick();
    chk({tag, "_e6_ce"}, 32'(ce), 32'h7);
    chk({tag, "_e6_sce"}, 32'(sel_ce), 0);
    tick();
    chk({tag, "_e7_ce"}, 32'(ce), 0);
    chk({tag, "_e7_sce"}, 32'(sel_ce), 1);
    tick();
    chk({tag, "_e8_ce"}, 32'(ce), 32'h7);
    chk({tag, "_e8_sce"}, 32'(sel_ce), 0);
  endtask

  initial begin
    logic [5:0] ch2_pat;
    RESET     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd0;
    sel       = 2'd0;
    repeat (2) tick();
    chk_reset_vals("rst");

    // Release and lock; edges counted from release.
    RESET = 1'b1;
    lock_sequence("lk");

    // ch1 -> 5 staged mid-period, retry stalls while pending.
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
    #1 chk("cfg1_rdy", 32'(cfg_ready), 1);
    tick();                                   // e9: accepted
    cfg_div = 8'd7;
    #1 chk("cfg1_stall", 32'(cfg_ready), 0);
    chk("e9_ce1", 32'(ce[1]), 0);
    tick();                                   // e10: wrap with ratio 2, apply 5
    chk("e10_ce1", 32'(ce[1]), 1);
    cfg_valid = 1'b0;
    #1 chk("cfg1_rdy_again", 32'(cfg_ready), 1);
    measure(1, 5, "ch1_per_a");               // e15
    measure(1, 5, "ch1_per_b");               // e20

    // ch2 -> 0 then 1: continuous enable.
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
    tick();                                   // e21
    cfg_valid = 1'b0;
    tick();                                   // e22: apply 0
    chk("e22_ce2", 32'(ce[2]), 1);
    cfg_valid = 1'b1; cfg_div = 8'd1;
    #1 chk("cfg2_rdy", 32'(cfg_ready), 1);
    tick();                                   // e23
    cfg_valid = 1'b0;
    chk("e23_ce2", 32'(ce[2]), 1);
    for (int e = 24; e <= 26; e++) begin
      tick();
      chk("ce2_cont", 32'(ce[2]), 1);
    end

    // ch2 -> 3: period 3 from the apply edge.
    cfg_valid = 1'b1; cfg_div = 8'd3;
    tick();                                   // e27
    cfg_valid = 1'b0;
    chk("e27_ce2", 32'(ce[2]), 1);
    tick();                                   // e28: apply
    chk("e28_ce2", 32'(ce[2]), 1);
    ch2_pat = 6'b100100;                      // e29..e34, lsb first
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("ce2_div3", 32'(ce[2]), 32'(ch2_pat[k]));
    end

    // ch0 -> 4, then switch sel 0 -> 2.
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
    tick();                                   // e35
    cfg_valid = 1'b0;
    tick();                                   // e36: ch0 wrap, apply 4
    chk("e36_ce0", 32'(ce[0]), 1);
    sel = 2'd2;
    tick();                                   // e37: IDLE -> WAIT_OLD
    chk("e37_sw", 32'(sel_switching), 1);
    chk("e37_sact", 32'(sel_active), 0);
    chk("e37_sce", 32'(sel_ce), 1);
    repeat (3) tick();                        // e40
    chk("e40_sact", 32'(sel_active), 0);
    chk("e40_sw", 32'(sel_switching), 1);
    tick();                                   // e41: old pulse, hand over
    chk("e41_sact", 32'(sel_active), 2);
    chk("e41_sce", 32'(sel_ce), 1);
    chk("e41_sw", 32'(sel_switching), 1);
    tick();                                   // e42
    chk("e42_sce", 32'(sel_ce), 0);
    tick();                                   // e43
    chk("e43_sce", 32'(sel_ce), 0);
    chk("e43_sw", 32'(sel_switching), 1);
    tick();                                   // e44: first new pulse
    chk("e44_sw", 32'(sel_switching), 0);
    chk("e44_sce", 32'(sel_ce), 1);
    tick();
    chk("e45_sce", 32'(sel_ce), 0);
    tick();
    chk("e46_sce", 32'(sel_ce), 0);
    tick();
    chk("e47_sce", 32'(sel_ce), 1);

    // Out-of-range sel and cfg_ch are ignored.
    sel = 2'd3;
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd9;
    #1 chk("cfg3_rdy", 32'(cfg_ready), 1);
    tick();                                   // e48
    cfg_valid = 1'b0;
    chk("e48_sact", 32'(sel_active), 2);
    chk("e48_sw", 32'(sel_switching), 0);
    tick();
    chk("e49_ce", 32'(ce), 32'h4);
    tick();
    chk("e50_ce", 32'(ce), 32'h2);
    tick();
    chk("e51_ce", 32'(ce), 32'h0);
    tick();
    chk("e52_ce", 32'(ce), 32'h5);
    chk("e52_sact", 32'(sel_active), 2);
    cfg_ch = 2'd0;
    #1 chk("cfg0_rdy", 32'(cfg_ready), 1);

    // Reset asserted while waiting for the old pulse.
    sel = 2'd0;
    tick();                                   // e53: IDLE -> WAIT_OLD
    chk("e53_sw", 32'(sel_switching), 1);
    #2 RESET = 1'b0;
    #1 chk_reset_vals("mid_rst");
    repeat (2) tick();
    RESET = 1'b1;
    lock_sequence("relk");
    chk("relk_sact", 32'(sel_active), 0);
    chk("relk_sw", 32'(sel_switching), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
